// File: rtl/vji_dr_scheduler.sv
// Virtual JTAG DR sequencer: captures, shifts and updates the bypass, timestamp,
// control and status data registers, and hands committed control words to user logic.
module vji_dr_scheduler #(
  parameter int CTRL_W = 16
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic [1:0]        ir_in,
  input  logic              tdi,
  input  logic              v_cdr,
  input  logic              v_sdr,
  input  logic              v_e1dr,
  input  logic              v_pdr,
  input  logic              v_e2dr,
  input  logic              v_udr,
  output logic              tdo,
  output logic [1:0]        ir_out,
  input  logic [45:0]       stamp_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  input  logic              ctrl_ready
);

  localparam logic [6:0] CtrlWidth = 7'(CTRL_W);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, PAUSE, UPDATE} state_e;

  state_e            state_q, state_d;
  logic              e2Seen_q, e2Seen_d;
  logic [63:0]       shift_q, shift_d;
  logic [6:0]        bitCnt_q, bitCnt_d;
  logic              bypass_q, bypass_d;
  logic [1:0]        scanIr_q, scanIr_d;
  logic [CTRL_W-1:0] ctrlOut_q, ctrlOut_d;
  logic              ctrlValid_q, ctrlValid_d;
  logic [5:0]        updCnt_q, updCnt_d;
  logic              overrun_q, overrun_d;
  logic              lengthErr_q, lengthErr_d;
  logic              clrPend_q, clrPend_d;

  logic              captureEn, shiftEn, commit, overrunEvt, lengthEvt;
  logic [6:0]        width;
  logic [63:0]       captureVal;

  function automatic logic [63:0] widthMask(input logic [6:0] w);
    if (w >= 7'd64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  always_ff @(posedge tck) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      e2Seen_q    <= 1'b0;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      bypass_q    <= 1'b0;
      scanIr_q    <= '0;
      ctrlOut_q   <= '0;
      ctrlValid_q <= 1'b0;
      updCnt_q    <= '0;
      overrun_q   <= 1'b0;
      lengthErr_q <= 1'b0;
      clrPend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      e2Seen_q    <= e2Seen_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      bypass_q    <= bypass_d;
      scanIr_q    <= scanIr_d;
      ctrlOut_q   <= ctrlOut_d;
      ctrlValid_q <= ctrlValid_d;
      updCnt_q    <= updCnt_d;
      overrun_q   <= overrun_d;
      lengthErr_q <= lengthErr_d;
      clrPend_q   <= clrPend_d;
    end
  end

  // Strobe tracking; a pause only resumes shifting once exit2 has been seen.
  always_comb begin
    state_d  = state_q;
    e2Seen_d = e2Seen_q;
    if (v_udr) begin
      state_d = UPDATE;
    end else if (v_cdr) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        UPDATE:  state_d = IDLE;
        CAPTURE: if (v_sdr) state_d = SHIFT;
        SHIFT:   if (v_e1dr || v_pdr) state_d = PAUSE;
        PAUSE: begin
          if (v_e2dr) e2Seen_d = 1'b1;
          else if (v_sdr && e2Seen_q) state_d = SHIFT;
        end
        default: state_d = state_q;
      endcase
    end
    if (state_d != PAUSE) e2Seen_d = 1'b0;
  end

  always_comb begin
    case (ir_in)
      2'd0:    width = 7'd1;
      2'd1:    width = 7'd46;
      2'd2:    width = CtrlWidth;
      default: width = 7'd8;
    endcase
    case (ir_in)
      2'd0:    captureVal = '0;
      2'd1:    captureVal = 64'(stamp_in);
      2'd2:    captureVal = 64'(ctrlOut_q);
      default: captureVal = 64'({overrun_q, lengthErr_q, updCnt_q});
    endcase
  end

  assign captureEn = v_cdr && !v_udr;
  assign shiftEn   = v_sdr && (state_d == SHIFT);

  always_comb begin
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    bypass_d = bypass_q;
    scanIr_d = scanIr_q;
    if (captureEn) begin
      shift_d  = captureVal;
      bitCnt_d = '0;
      bypass_d = 1'b0;
      scanIr_d = ir_in;
    end else if (shiftEn) begin
      shift_d  = ((shift_q >> 1) & widthMask(width - 7'd1)) | ({63'd0, tdi} << (width - 7'd1));
      bitCnt_d = (bitCnt_q == 7'd127) ? bitCnt_q : bitCnt_q + 7'd1;
      bypass_d = tdi;
      scanIr_d = ir_in;
    end
  end

  // A commit into a word being consumed this cycle keeps valid high.
  always_comb begin
    commit     = 1'b0;
    overrunEvt = 1'b0;
    lengthEvt  = 1'b0;
    if (state_q == UPDATE && ir_in == 2'd2) begin
      if (bitCnt_q != CtrlWidth) lengthEvt = 1'b1;
      else if (ctrlValid_q && !ctrl_ready) overrunEvt = 1'b1;
      else commit = 1'b1;
    end

    ctrlOut_d   = ctrlOut_q;
    ctrlValid_d = ctrlValid_q;
    updCnt_d    = updCnt_q;
    if (ctrlValid_q && ctrl_ready) ctrlValid_d = 1'b0;
    if (commit) begin
      ctrlOut_d   = shift_q[CTRL_W-1:0];
      ctrlValid_d = 1'b1;
      updCnt_d    = updCnt_q + 6'd1;
    end

    clrPend_d   = captureEn && (ir_in == 2'd3);
    overrun_d   = overrunEvt || (overrun_q && !clrPend_q);
    lengthErr_d = lengthEvt || (lengthErr_q && !clrPend_q);
  end

  assign tdo        = (scanIr_q == 2'd0) ? bypass_q : shift_q[0];
  assign ir_out     = {ctrlValid_q, lengthErr_q | overrun_q};
  assign ctrl_out   = ctrlOut_q;
  assign ctrl_valid = ctrlValid_q;

endmodule

// File: tb/tb_vji_dr_scheduler.sv
// Directed bench for vji_dr_scheduler: a table of DR scan transactions with
// hand-computed results, plus sequences for reset, latency and circular timestamp shifts.
module tb_vji_dr_scheduler;

  localparam int CTRL_W = 16;

  logic              tck = 1'b0;
  logic              reset_n;
  logic [1:0]        ir_in;
  logic              tdi;
  logic              v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr;
  logic              tdo;
  logic [1:0]        ir_out;
  logic [45:0]       stamp_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic              ctrl_valid;
  logic              ctrl_ready;

  int vecCount  = 0;
  int missCount = 0;

  always #5 tck = ~tck;

  vji_dr_scheduler #(.CTRL_W(CTRL_W)) dut (
    .tck(tck), .reset_n(reset_n), .ir_in(ir_in), .tdi(tdi),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .v_e1dr(v_e1dr), .v_pdr(v_pdr),
    .v_e2dr(v_e2dr), .v_udr(v_udr), .tdo(tdo), .ir_out(ir_out),
    .stamp_in(stamp_in), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready)
  );

  typedef struct {
    logic [1:0]  ir;
    int          nBits;
    logic [63:0] din;
    bit          pop;
    bit          doUpd;
    bit          rdyUpd;
    logic [63:0] expOut;
    logic [15:0] expCtrl;
    logic        expValid;
    logic [1:0]  expIrOut;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic captureDr(input logic [1:0] ir);
    ir_in = ir;
    v_cdr = 1'b1;
    step();
    v_cdr = 1'b0;
  endtask

  task automatic shiftDr(input int n, input logic [63:0] din, input bit loopBack,
                         output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tdi     = loopBack ? tdo : din[i];
      v_sdr   = 1'b1;
      step();
    end
    v_sdr = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic updateDr(input bit rdy);
    v_udr = 1'b1;
    step();
    v_udr      = 1'b0;
    ctrl_ready = rdy;
    step();
    ctrl_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [63:0] dout);
    if (v.pop) begin
      ctrl_ready = 1'b1;
      step();
      ctrl_ready = 1'b0;
    end
    captureDr(v.ir);
    shiftDr(v.nBits, v.din, 1'b0, dout);
    if (v.doUpd) updateDr(v.rdyUpd);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] stampVal;

    reset_n = 1'b0; ir_in = '0; tdi = 1'b0;
    v_cdr = 1'b0; v_sdr = 1'b0; v_e1dr = 1'b0; v_pdr = 1'b0; v_e2dr = 1'b0; v_udr = 1'b0;
    ctrl_ready = 1'b0;
    stamp_in = 46'h2A_5555_AAAA_1;
    stampVal = 64'(stamp_in);

    // Fields: ir, nBits, din, pop, doUpd, rdyUpd, expOut, expCtrl, expValid, expIrOut
    vecs[0]  = '{2'd2, 16, 64'hBEEF,  1'b0, 1'b1, 1'b0, 64'h0,     16'hBEEF, 1'b1, 2'b10};
    vecs[1]  = '{2'd3,  8, 64'h0,     1'b1, 1'b0, 1'b0, 64'h01,    16'hBEEF, 1'b0, 2'b00};
    vecs[2]  = '{2'd2, 15, 64'h1234,  1'b0, 1'b1, 1'b0, 64'h3EEF,  16'hBEEF, 1'b0, 2'b01};
    vecs[3]  = '{2'd3,  8, 64'h0,     1'b0, 1'b0, 1'b0, 64'h41,    16'hBEEF, 1'b0, 2'b00};
    vecs[4]  = '{2'd3,  8, 64'h0,     1'b0, 1'b0, 1'b0, 64'h01,    16'hBEEF, 1'b0, 2'b00};
    vecs[5]  = '{2'd2, 16, 64'h1234,  1'b0, 1'b1, 1'b0, 64'hBEEF,  16'h1234, 1'b1, 2'b10};
    vecs[6]  = '{2'd2, 16, 64'h5678,  1'b0, 1'b1, 1'b0, 64'h1234,  16'h1234, 1'b1, 2'b11};
    vecs[7]  = '{2'd2, 16, 64'h5678,  1'b0, 1'b1, 1'b1, 64'h1234,  16'h5678, 1'b1, 2'b11};
    vecs[8]  = '{2'd3,  8, 64'h0,     1'b0, 1'b0, 1'b0, 64'h83,    16'h5678, 1'b1, 2'b10};
    vecs[9]  = '{2'd0, 10, 64'h2CE,   1'b0, 1'b0, 1'b0, 64'h19C,   16'h5678, 1'b1, 2'b10};
    vecs[10] = '{2'd2, 20, 64'hA5A5A, 1'b0, 1'b1, 1'b0, 64'hA5678, 16'h5678, 1'b1, 2'b11};
    vecs[11] = '{2'd3,  8, 64'h0,     1'b1, 1'b0, 1'b0, 64'h43,    16'h5678, 1'b0, 2'b00};

    step();
    step();
    checkOutput("reset.tdo",        64'(tdo),        64'h0);
    checkOutput("reset.ctrl_valid", 64'(ctrl_valid), 64'h0);
    checkOutput("reset.ctrl_out",   64'(ctrl_out),   64'h0);
    checkOutput("reset.ir_out",     64'(ir_out),     64'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], got);
      checkOutput($sformatf("v%0d.tdoBits", i),   got,                   vecs[i].expOut);
      checkOutput($sformatf("v%0d.ctrl_out", i),  64'(ctrl_out),         64'(vecs[i].expCtrl));
      checkOutput($sformatf("v%0d.ctrl_valid", i), 64'(ctrl_valid),      64'(vecs[i].expValid));
      checkOutput($sformatf("v%0d.ir_out", i),    64'(ir_out),           64'(vecs[i].expIrOut));
    end

    // Commit latency: valid rises one tck after the v_udr edge.
    captureDr(2'd2);
    shiftDr(16, 64'hC3C3, 1'b0, got);
    checkOutput("lat.tdoBits", got, 64'h5678);
    v_udr = 1'b1;
    step();
    v_udr = 1'b0;
    checkOutput("lat.validEarly", 64'(ctrl_valid), 64'h0);
    step();
    checkOutput("lat.validLate", 64'(ctrl_valid), 64'h1);
    checkOutput("lat.ctrl_out",  64'(ctrl_out),   64'hC3C3);

    // Timestamp readback, then a second lap with tdi looped back to tdo.
    captureDr(2'd1);
    shiftDr(46, 64'h0, 1'b1, got);
    checkOutput("stamp.lap1", got, stampVal);
    shiftDr(46, 64'h0, 1'b1, got);
    checkOutput("stamp.lap2", got, stampVal);

    // Reset during a shift, then during the update cycle: nothing commits.
    captureDr(2'd2);
    shiftDr(8, 64'hFF, 1'b0, got);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checkOutput("rstShift.ctrl_valid", 64'(ctrl_valid), 64'h0);
    checkOutput("rstShift.ctrl_out",   64'(ctrl_out),   64'h0);
    checkOutput("rstShift.ir_out",     64'(ir_out),     64'h0);
    checkOutput("rstShift.tdo",        64'(tdo),        64'h0);

    captureDr(2'd2);
    shiftDr(16, 64'hFFFF, 1'b0, got);
    v_udr = 1'b1;
    step();
    v_udr   = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checkOutput("rstUpd.ctrl_valid", 64'(ctrl_valid), 64'h0);
    checkOutput("rstUpd.ir_out",     64'(ir_out),     64'h0);
    checkOutput("rstUpd.ctrl_out",   64'(ctrl_out),   64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
